cpu_trace_emitter: RTL and testbench

Serializes one CPU retirement record per handshake into the ASCII trace line format, one character per clock. Two line forms: register write `^T@PPPPPPPP: $R <= DDDDDDDD#` and memory write `^T@PPPPPPPP: *AAAAAAAA <= DDDDDDDD#`. The block sits between the CPU model's retire port and the trace checker or log sink, and is the transmit end of the character stream the checker parses.

---
 rtl/cpu_trace_pkg.sv | 42 ++++
 rtl/trace_bin2dec.sv | 31 +++
 rtl/cpu_trace_emitter.sv | 131 +++++++++++++
 tb/tb_cpu_trace_emitter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared constants for the CPU trace emitter: ASCII codes, FSM state codes,
// record type codes and the nibble-to-hex helper.
`timescale 1ns/1ps
package cpu_trace_pkg;

   localparam logic [7:0] CH_CARET  = 8'h5E;
   localparam logic [7:0] CH_AT     = 8'h40;
   localparam logic [7:0] CH_COLON  = 8'h3A;
   localparam logic [7:0] CH_SP     = 8'h20;
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [7:0] CH_LT     = 8'h3C;
   localparam logic [7:0] CH_EQ     = 8'h3D;
   localparam logic [7:0] CH_HASH   = 8'h23;
   localparam logic [7:0] CH_LF     = 8'h0A;

   localparam logic TYPE_REG = 1'b0;
   localparam logic TYPE_MEM = 1'b1;

   localparam logic [4:0] S_IDLE  = 5'd0;
   localparam logic [4:0] S_CARET = 5'd1;
   localparam logic [4:0] S_TIME  = 5'd2;
   localparam logic [4:0] S_AT    = 5'd3;
   localparam logic [4:0] S_PC    = 5'd4;
   localparam logic [4:0] S_COLON = 5'd5;
   localparam logic [4:0] S_SP_A  = 5'd6;
   localparam logic [4:0] S_TAG   = 5'd7;
   localparam logic [4:0] S_REG   = 5'd8;
   localparam logic [4:0] S_ADDR  = 5'd9;
   localparam logic [4:0] S_SP_B  = 5'd10;
   localparam logic [4:0] S_LT    = 5'd11;
   localparam logic [4:0] S_EQ    = 5'd12;
   localparam logic [4:0] S_SP_C  = 5'd13;
   localparam logic [4:0] S_DATA  = 5'd14;
   localparam logic [4:0] S_HASH  = 5'd15;
   localparam logic [4:0] S_NL    = 5'd16;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

endpackage

// File: rtl/trace_bin2dec.sv
// Combinational double-dabble: 14-bit binary to four BCD digits plus the
// count of significant digits (1..4, so zero reports one digit).
`timescale 1ns/1ps
module trace_bin2dec (
   input  logic [13:0] bin,
   output logic [15:0] bcd,
   output logic [2:0]  ndig
);

   logic [29:0] sh;

   always_comb begin
      sh = {16'h0000, bin};
      for (int i = 0; i < 14; i++) begin
         for (int d = 0; d < 4; d++) begin
            if (sh[14+4*d +: 4] >= 4'd5)
               sh[14+4*d +: 4] = sh[14+4*d +: 4] + 4'd3;
         end
         sh = {sh[28:0], 1'b0};
      end
      bcd = sh[29:14];
   end

   always_comb begin
      if (bcd[15:12] != 4'd0)     ndig = 3'd4;
      else if (bcd[11:8] != 4'd0) ndig = 3'd3;
      else if (bcd[7:4] != 4'd0)  ndig = 3'd2;
      else                        ndig = 3'd1;
   end

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serializes one retirement record per handshake into an ASCII trace line.
// Optional macro CPU_TRACE_NEWLINE_EN appends an LF after the closing '#'.
`timescale 1ns/1ps
module cpu_trace_emitter
   import cpu_trace_pkg::*;
#(
   parameter int TIME_MAX = 9999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_type,
   input  logic [13:0] in_time,
   input  logic [31:0] in_pc,
   input  logic [4:0]  in_reg,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_data,
   output logic [7:0]  char_out,
   output logic        char_valid,
   input  logic        char_ready,
   output logic        busy
);

   localparam logic [13:0] TMAX = 14'(TIME_MAX);

   logic [4:0]  state;
   logic [2:0]  idx;
   logic        typ_q;
   logic [31:0] pc_q, addr_q, data_q;
   logic [15:0] t_bcd_q;
   logic [2:0]  t_n_q;
   logic [7:0]  r_bcd_q;
   logic [2:0]  r_n_q;

   logic [13:0] t_sat;
   logic [15:0] t_bcd, r_bcd;
   logic [2:0]  t_n, r_n;
   logic        unused_r_bcd;
   logic        active, last, fire, accept;
   logic [7:0]  ch;

   assign t_sat = (in_time > TMAX) ? TMAX : in_time;

   trace_bin2dec u_time (.bin(t_sat),           .bcd(t_bcd), .ndig(t_n));
   trace_bin2dec u_reg  (.bin({9'd0, in_reg}),  .bcd(r_bcd), .ndig(r_n));

   assign unused_r_bcd = ^r_bcd[15:8];

   // Outputs are gated by reset so nothing leaks while reset is held.
   assign active     = reset && (state != S_IDLE);
   assign char_valid = active;
   assign busy       = active;
   assign char_out   = active ? ch : 8'h00;
`ifdef CPU_TRACE_NEWLINE_EN
   assign last = (state == S_NL);
`else
   assign last = (state == S_HASH);
`endif
   assign fire     = active && char_ready;
   assign in_ready = reset && ((state == S_IDLE) || (last && char_ready));
   assign accept   = in_valid && in_ready;

   always_comb begin
      ch = 8'h00;
      case (state)
         S_CARET: ch = CH_CARET;
         S_TIME:  ch = {4'h3, t_bcd_q[{idx[1:0], 2'b00} +: 4]};
         S_AT:    ch = CH_AT;
         S_PC:    ch = hex_char(pc_q[{idx, 2'b00} +: 4]);
         S_COLON: ch = CH_COLON;
         S_SP_A, S_SP_B, S_SP_C: ch = CH_SP;
         S_TAG:   ch = (typ_q == TYPE_MEM) ? CH_STAR : CH_DOLLAR;
         S_REG:   ch = {4'h3, r_bcd_q[{idx[0], 2'b00} +: 4]};
         S_ADDR:  ch = hex_char(addr_q[{idx, 2'b00} +: 4]);
         S_LT:    ch = CH_LT;
         S_EQ:    ch = CH_EQ;
         S_DATA:  ch = hex_char(data_q[{idx, 2'b00} +: 4]);
         S_HASH:  ch = CH_HASH;
         S_NL:    ch = CH_LF;
         default: ch = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
         idx   <= 3'd0;
      end else if ((state == S_IDLE) || (fire && last)) begin
         state <= accept ? S_CARET : S_IDLE;
      end else if (fire) begin
         case (state)
            S_CARET: begin state <= S_TIME; idx <= t_n_q - 3'd1; end
            S_TIME:  if (idx == 3'd0) state <= S_AT; else idx <= idx - 3'd1;
            S_AT:    begin state <= S_PC; idx <= 3'd7; end
            S_PC:    if (idx == 3'd0) state <= S_COLON; else idx <= idx - 3'd1;
            S_COLON: state <= S_SP_A;
            S_SP_A:  state <= S_TAG;
            S_TAG: begin
               if (typ_q == TYPE_MEM) begin state <= S_ADDR; idx <= 3'd7; end
               else begin state <= S_REG; idx <= r_n_q - 3'd1; end
            end
            S_REG, S_ADDR: if (idx == 3'd0) state <= S_SP_B; else idx <= idx - 3'd1;
            S_SP_B:  state <= S_LT;
            S_LT:    state <= S_EQ;
            S_EQ:    state <= S_SP_C;
            S_SP_C:  begin state <= S_DATA; idx <= 3'd7; end
            S_DATA:  if (idx == 3'd0) state <= S_HASH; else idx <= idx - 3'd1;
`ifdef CPU_TRACE_NEWLINE_EN
            S_HASH:  state <= S_NL;
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

   // Decimal digits are captured alongside the raw fields at accept time.
   always_ff @(posedge clk) begin
      if (accept) begin
         typ_q   <= in_type;
         pc_q    <= in_pc;
         addr_q  <= in_addr;
         data_q  <= in_data;
         t_bcd_q <= t_bcd;
         t_n_q   <= t_n;
         r_bcd_q <= r_bcd[7:0];
         r_n_q   <= r_n;
      end
   end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Scoreboard bench for cpu_trace_emitter: expected characters are queued at
// accept time and checked cycle by cycle against the character stream.
`timescale 1ns/1ps
module tb_cpu_trace_emitter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_type = 1'b0;
   logic [13:0] in_time = '0;
   logic [31:0] in_pc = '0;
   logic [4:0]  in_reg = '0;
   logic [31:0] in_addr = '0;
   logic [31:0] in_data = '0;
   logic [7:0]  char_out;
   logic        char_valid;
   logic        char_ready = 1'b1;
   logic        busy;

   logic [7:0]  q[$];
   int          vectors = 0;
   int          miscompares = 0;
   bit          exp_caret = 1'b0;
`ifdef CPU_TRACE_NEWLINE_EN
   localparam int NL = 1;
`else
   localparam int NL = 0;
`endif

   cpu_trace_emitter #(.TIME_MAX(9999)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_type(in_type), .in_time(in_time), .in_pc(in_pc), .in_reg(in_reg),
      .in_addr(in_addr), .in_data(in_data), .char_out(char_out),
      .char_valid(char_valid), .char_ready(char_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic string line_str(input logic t, input int tm, input logic [31:0] pc,
                                      input int rg, input logic [31:0] ad, input logic [31:0] dt);
      int ts;
      ts = (tm > 9999) ? 9999 : tm;
      if (t) return $sformatf("^%0d@%08h: *%08h <= %08h#", ts, pc, ad, dt);
      return $sformatf("^%0d@%08h: $%0d <= %08h#", ts, pc, rg, dt);
   endfunction

   // Reference model of the handshake plus the expected character stream.
   always @(negedge clk) begin
      if (!reset) begin
         chk("rst_char_valid", char_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_char_out", char_out, 0);
         q.delete();
         exp_caret = 1'b0;
      end else begin
         bit exp_rdy;
         string s;
         exp_rdy = (q.size() == 0) || (q.size() == 1 && char_ready);
         chk("in_ready", in_ready, exp_rdy);
         chk("busy", busy, q.size() != 0);
         chk("char_valid", char_valid, q.size() != 0);
         if (exp_caret) chk("caret_latency", char_out, 8'h5E);
         exp_caret = 1'b0;
         if (q.size() != 0) begin
            chk("char", char_out, q[0]);
            if (char_ready) void'(q.pop_front());
         end
         if (in_valid && exp_rdy) begin
            s = line_str(in_type, int'(in_time), in_pc, int'(in_reg), in_addr, in_data);
            for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
            if (NL == 1) q.push_back(8'h0A);
            exp_caret = 1'b1;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic t, input int tm, input logic [31:0] pc, input logic [4:0] rg,
                       input logic [31:0] ad, input logic [31:0] dt, input bit rnd);
      bit got;
      got = 1'b0;
      in_type = t; in_time = tm[13:0]; in_pc = pc; in_reg = rg; in_addr = ad; in_data = dt;
      in_valid = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (in_ready) begin got = 1'b1; break; end
         @(posedge clk); #1;
         if (rnd) char_ready = 1'($urandom_range(0, 1));
      end
      chk("accept_timeout", got, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input bit rnd);
      for (int c = 0; c < 2000; c++) begin
         if (q.size() == 0) break;
         @(posedge clk); #1;
         if (rnd) char_ready = 1'($urandom_range(0, 1));
      end
      char_ready = 1'b1;
      chk("idle_timeout", q.size(), 0);
   endtask

   task automatic line_len(input string tag, input int exp);
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, n, exp);
   endtask

   initial begin
      int len;
      bit sp, sh;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;

      // basic register and memory lines at full rate
      send(0, 5, 32'h0000_3000, 5'd3, 32'h0, 32'h0000_abcd, 0);
      line_len("len_reg", 28 + NL);
      send(1, 1234, 32'h0000_4ffc, 5'd0, 32'h0000_0010, 32'hdead_beef, 0);
      line_len("len_mem", 38 + NL);

      // edge values, including time saturation
      send(0, 0, 32'h1234_5678, 5'd31, 32'h0, 32'hffff_ffff, 0);
      wait_idle(0);
      send(0, 12000, 32'h89ab_cdef, 5'd0, 32'h0, 32'h0, 0);
      wait_idle(0);
      send(0, 9999, 32'h0, 5'd10, 32'h0, 32'h0102_0304, 0);
      wait_idle(0);
      send(1, 16383, 32'hffff_fffc, 5'd7, 32'hcafe_f00d, 32'h0, 0);
      wait_idle(0);

      // backpressure on the first pc nibble and on '#', with a record offered while busy
      send(0, 5, 32'h0000_3000, 5'd3, 32'h0, 32'h0000_abcd, 0);
      len = q.size();
      sp = 1'b0; sh = 1'b0;
      for (int c = 0; c < 200 && q.size() != 0; c++) begin
         if (!sp && q.size() == len - 3) begin
            sp = 1'b1;
            char_ready = 1'b0;
            in_type = 1'b1; in_time = 14'd77; in_pc = 32'h5555_5555; in_valid = 1'b1;
            repeat (3) begin @(posedge clk); #1; end
            in_valid = 1'b0;
            char_ready = 1'b1;
         end else if (!sh && q.size() != 0 && q[0] == 8'h23) begin
            sh = 1'b1;
            char_ready = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
            char_ready = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      chk("stall_p_hit", sp, 1);
      chk("stall_hash_hit", sh, 1);
      wait_idle(0);

      // back-to-back: next record offered on the final character
      send(0, 42, 32'h0000_1000, 5'd12, 32'h0, 32'h1111_2222, 0);
      for (int c = 0; c < 100 && q.size() > 1; c++) begin @(posedge clk); #1; end
      send(1, 7, 32'h0000_1004, 5'd0, 32'h0000_0200, 32'h3333_4444, 0);
      wait_idle(0);

      // reset at the 10th character, then a normal line
      send(1, 88, 32'habcd_0000, 5'd0, 32'h0000_0040, 32'h5a5a_5a5a, 0);
      len = q.size();
      for (int c = 0; c < 100 && q.size() > len - 9; c++) begin @(posedge clk); #1; end
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      send(0, 3, 32'h0000_0008, 5'd1, 32'h0, 32'h0000_0001, 0);
      wait_idle(0);

      // random records under random backpressure
      for (int r = 0; r < 8; r++)
         send(1'($urandom_range(0, 1)), int'($urandom_range(0, 16383)), $urandom,
              5'($urandom_range(0, 31)), $urandom, $urandom, 1);
      wait_idle(1);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
